// File: rtl/uart_rx_fifo.sv
// Purpose: buffered 8N1 UART receiver. Each bit is a 3-sample majority vote at mid-bit.
//          Start-bit glitches are rejected and framing/overrun errors are flagged.
//          Received bytes go into a show-ahead FIFO.
// Latency: a byte is pushed at the mid-stop vote. dout/rxd_rdy reflect it one clk later.
// Backpressure: none toward the line. A byte that arrives while the FIFO is full is dropped
//          and overrun is set, unless rd_en pops in the same cycle.
//
// Ports: clk, rst (sync, active-high), ser_rxd (async serial in), rd_en (pop head),
//        err_clr (clear sticky flags), dout (head byte), rxd_rdy (not empty),
//        fifo_full, count (occupancy), frame_err, overrun (sticky error flags).

// Generic synchronous FIFO with show-ahead head and pointer-based full/empty.
// Latency: a write is visible on dout one clk later. A pop advances the head one clk later.
// Backpressure: a push while full is refused (drop=1) unless a pop happens in the same cycle.
module fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          drop
);
  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          pop_en;
  logic          wr_en;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count  = wr_ptr - rd_ptr;
  assign pop_en = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign wr_en  = push && (!full || pop_en);
  assign drop   = push && !wr_en;
  // The head reads as zero while empty, so no memory reset is needed.
  assign dout   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module uart_rx_fifo #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_AW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ser_rxd,
  input  logic               rd_en,
  input  logic               err_clr,
  output logic [7:0]         dout,
  output logic               rxd_rdy,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   count,
  output logic               frame_err,
  output logic               overrun
);
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] H    = 16'(BAUD_DIV / 2);
  localparam logic [15:0] HM1  = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] HP1  = 16'(BAUD_DIV / 2 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic        s0;
  logic        s1;
  logic        maj;
  logic [7:0]  sr;
  logic        wrap;
  logic        at_vote;
  logic        push;
  logic        frame_set;
  logic        fifo_empty;
  logic        fifo_drop;

  // Two-flop synchroniser. It resets to the idle line level so that reset cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= ser_rxd;
      rx_s <= rx_m;
    end
  end

  assign wrap    = (timer == LAST);
  assign at_vote = (timer == HP1);
  // The third sample is the live rx_s at H+1. The vote is consumed in that same cycle.
  assign maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: begin
        if (timer == H && rx_s) state_nxt = IDLE;
        else if (wrap)          state_nxt = DATA;
      end
      DATA:  if (wrap && bit_idx == 3'd7) state_nxt = STOP;
      // Leaving at mid-stop gives half a bit of margin to catch a back-to-back start edge.
      STOP:  if (at_vote) state_nxt = maj ? IDLE : BRK;
      BRK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
    if (state == STOP && at_vote) begin
      push      = maj;
      frame_set = !maj;
    end
  end

  // Bit timer, vote samples, bit index and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      bit_idx <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      sr      <= '0;
    end else begin
      // Hold at 0 both while idle and on the edge into IDLE/BRK.
      // This way a new frame always starts counting from 0.
      if (state == IDLE || state == BRK || state_nxt == IDLE || state_nxt == BRK)
        timer <= '0;
      else if (wrap)
        timer <= '0;
      else
        timer <= timer + 16'd1;

      if (timer == HM1) s0 <= rx_s;
      if (timer == H)   s1 <= rx_s;

      if (state == START && wrap)     bit_idx <= '0;
      else if (state == DATA && wrap) bit_idx <= bit_idx + 3'd1;

      if (state == DATA && at_vote) sr <= {maj, sr[7:1]};
    end
  end

  fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sr),
    .pop   (rd_en),
    .dout  (dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count),
    .drop  (fifo_drop)
  );

  assign rxd_rdy = !fifo_empty;

  // Sticky flags. A set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (fifo_drop)    overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end
endmodule
